// File: rtl/corr_pkg.sv
// Shared constants and the sign-flip helper for the preamble correlator.
package corr_pkg;

    localparam int CORR_DATA_W = 16;
    localparam int CORR_LEN    = 16;
    localparam int CORR_SUM_W  = 32;

    // Preamble signs, bit k -> tap k: 1 = +1, 0 = -1
    localparam logic [15:0] CORR_COEF_I = 16'hFFFF;
    localparam logic [15:0] CORR_COEF_Q = 16'h0000;

    // Multiply a sample by +/-1. The result is one bit wider so that the most
    // negative input value negates exactly instead of wrapping.
    function automatic logic signed [CORR_DATA_W:0] sgn_apply(
        input logic signed [CORR_DATA_W-1:0] x,
        input logic                          c
    );
        logic signed [CORR_DATA_W:0] xe;
        xe = {x[CORR_DATA_W-1], x};
        return c ? xe : -xe;
    endfunction

endpackage

// File: rtl/corr_adder_tree.sv
// Signed N-input sum with one registered output stage and a matching valid bit.
module corr_adder_tree #(
    parameter int N     = 16,
    parameter int IN_W  = 18,
    parameter int OUT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_terms [N],
    output logic                    o_valid,
    output logic signed [OUT_W-1:0] o_sum
);

    logic signed [OUT_W-1:0] w_sum;
    logic signed [OUT_W-1:0] r_sum;
    logic                    r_valid;

    // Sign-extend every term into the wide accumulator; synthesis balances the chain into a tree
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = w_sum + OUT_W'(i_terms[k]);
        end
    end

    // Capture the sum only on valid so the output holds between strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sum <= w_sum;
            end
        end
    end

    assign o_sum   = r_sum;
    assign o_valid = r_valid;

endmodule

// File: rtl/preamble_correlator.sv
// Sliding-window complex correlator against a fixed +/-1 preamble.
// The sign helper in corr_pkg is sized by CORR_DATA_W, so sample width changes belong there.
module preamble_correlator
    import corr_pkg::*;
#(
    parameter int             DATA_W = CORR_DATA_W,
    parameter int             LEN    = CORR_LEN,
    parameter int             SUM_W  = CORR_SUM_W,
    parameter logic [LEN-1:0] COEF_I = CORR_COEF_I,
    parameter logic [LEN-1:0] COEF_Q = CORR_COEF_Q
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic signed [DATA_W-1:0] in_q,
    output logic                     out_valid,
    output logic signed [SUM_W-1:0]  I_sum,
    output logic signed [SUM_W-1:0]  Q_sum,
    output logic                     fill_done
);

    localparam int TERM_W = DATA_W + 2;
    localparam int CNT_W  = $clog2(LEN + 1);

    logic signed [DATA_W-1:0] r_lineI [LEN];
    logic signed [DATA_W-1:0] r_lineQ [LEN];
    logic signed [TERM_W-1:0] w_termI [LEN];
    logic signed [TERM_W-1:0] w_termQ [LEN];
    logic signed [TERM_W-1:0] r_termI [LEN];
    logic signed [TERM_W-1:0] r_termQ [LEN];
    logic [CNT_W-1:0]         r_fillCount;
    logic                     r_tagValid;
    logic                     r_termValid;
    logic                     w_accept;
    logic                     w_treeValid;
    logic                     w_validI;
    logic                     w_validQ;

    // clear takes priority, so a sample arriving with it is dropped
    assign w_accept    = in_valid & ~clear;
    // A result already in the term stage is killed by clear before it reaches the output
    assign w_treeValid = r_termValid & ~clear;

    // Delay line: tap 0 is the newest sample, shifting only on an accepted sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LEN; k++) begin
                r_lineI[k] <= '0;
                r_lineQ[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < LEN; k++) begin
                r_lineI[k] <= '0;
                r_lineQ[k] <= '0;
            end
        end else if (w_accept) begin
            r_lineI[0] <= in_i;
            r_lineQ[0] <= in_q;
            for (int k = 1; k < LEN; k++) begin
                r_lineI[k] <= r_lineI[k-1];
                r_lineQ[k] <= r_lineQ[k-1];
            end
        end
    end

    // Fill counter saturates at LEN; a sample is tagged valid once it completes the window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fillCount <= '0;
            r_tagValid  <= 1'b0;
        end else if (clear) begin
            r_fillCount <= '0;
            r_tagValid  <= 1'b0;
        end else begin
            r_tagValid <= w_accept && (r_fillCount >= CNT_W'(LEN - 1));
            if (w_accept && (r_fillCount != CNT_W'(LEN))) begin
                r_fillCount <= r_fillCount + 1'b1;
            end
        end
    end

    assign fill_done = (r_fillCount == CNT_W'(LEN));

    // Per-tap product with conj(c): I*cI + Q*cQ and Q*cI - I*cQ, done as sign flips
    always_comb begin
        for (int k = 0; k < LEN; k++) begin
            w_termI[k] = TERM_W'(sgn_apply(r_lineI[k], COEF_I[k]))
                       + TERM_W'(sgn_apply(r_lineQ[k], COEF_Q[k]));
            w_termQ[k] = TERM_W'(sgn_apply(r_lineQ[k], COEF_I[k]))
                       + TERM_W'(sgn_apply(r_lineI[k], ~COEF_Q[k]));
        end
    end

    // Term stage registers the products of a tagged window and carries its valid bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LEN; k++) begin
                r_termI[k] <= '0;
                r_termQ[k] <= '0;
            end
            r_termValid <= 1'b0;
        end else begin
            r_termValid <= r_tagValid & ~clear;
            if (r_tagValid) begin
                r_termI <= w_termI;
                r_termQ <= w_termQ;
            end
        end
    end

    corr_adder_tree #(
        .N     (LEN),
        .IN_W  (TERM_W),
        .OUT_W (SUM_W)
    ) u_treeI (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_valid (w_treeValid),
        .i_terms (r_termI),
        .o_valid (w_validI),
        .o_sum   (I_sum)
    );

    corr_adder_tree #(
        .N     (LEN),
        .IN_W  (TERM_W),
        .OUT_W (SUM_W)
    ) u_treeQ (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_valid (w_treeValid),
        .i_terms (r_termQ),
        .o_valid (w_validQ),
        .o_sum   (Q_sum)
    );

    assign out_valid = w_validI & w_validQ;

endmodule

// File: tb/tb_preamble_correlator.sv
// Directed bench for preamble_correlator with default preamble (COEF_I all +1, COEF_Q all -1).
module tb_preamble_correlator;

    logic               clk;
    logic               reset_n;
    logic               clear;
    logic               in_valid;
    logic signed [15:0] in_i;
    logic signed [15:0] in_q;
    logic               out_valid;
    logic signed [31:0] I_sum;
    logic signed [31:0] Q_sum;
    logic               fill_done;

    int compareCount  = 0;
    int mismatchCount = 0;
    int validCount    = 0;
    int countMark;

    logic               captureEn = 1'b0;
    logic               holdEn    = 1'b0;
    logic signed [31:0] capI [$];
    logic signed [31:0] capQ [$];
    logic signed [31:0] lastI;
    logic signed [31:0] lastQ;

    preamble_correlator dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .I_sum     (I_sum),
        .Q_sum     (Q_sum),
        .fill_done (fill_done)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and report any difference
    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one accepted sample for a single cycle, returning just after the accepting edge
    task automatic applyStimulus(input logic signed [15:0] si, input logic signed [15:0] sq,
                                 input logic withClear);
        in_valid = 1'b1;
        in_i     = si;
        in_q     = sq;
        clear    = withClear;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe monitor on the falling edge: counts strobes, captures results, checks hold
    always @(negedge clk) begin
        if (out_valid) begin
            validCount++;
            if (captureEn) begin
                capI.push_back(I_sum);
                capQ.push_back(Q_sum);
            end
            lastI = I_sum;
            lastQ = Q_sum;
        end else if (holdEn) begin
            checkOutput("hold_I", I_sum, lastI);
            checkOutput("hold_Q", Q_sum, lastQ);
        end
    end

    // Refill with 16 samples of (1000,0): silent for 15, then 16000/16000
    task automatic refillCheck(input string tag);
        countMark = validCount;
        for (int j = 0; j < 15; j++) applyStimulus(16'sd1000, 16'sd0, 1'b0);
        idleCycles(3);
        checkOutput({tag, "_no_valid_15"}, validCount - countMark, 0);
        checkOutput({tag, "_fill_15"}, fill_done, 1'b0);
        applyStimulus(16'sd1000, 16'sd0, 1'b0);
        checkOutput({tag, "_fill_16"}, fill_done, 1'b1);
        checkOutput({tag, "_valid_p1"}, out_valid, 1'b0);
        idleCycles(1);
        checkOutput({tag, "_valid_p1b"}, out_valid, 1'b0);
        idleCycles(1);
        checkOutput({tag, "_valid_p2"}, out_valid, 1'b1);
        checkOutput({tag, "_I"}, I_sum, 16000);
        checkOutput({tag, "_Q"}, Q_sum, 16000);
        idleCycles(1);
        checkOutput({tag, "_strobe_len"}, out_valid, 1'b0);
        checkOutput({tag, "_hold_I"}, I_sum, 16000);
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_i     = '0;
        in_q     = '0;

        // Test 1: reset with random inputs, then idle
        repeat (5) begin
            in_valid = 1'($urandom);
            clear    = 1'($urandom);
            in_i     = 16'($urandom);
            in_q     = 16'($urandom);
            @(posedge clk);
            #1;
        end
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_I", I_sum, 0);
        checkOutput("rst_Q", Q_sum, 0);
        checkOutput("rst_fill", fill_done, 1'b0);
        in_valid = 1'b0;
        clear    = 1'b0;
        reset_n  = 1'b1;
        idleCycles(3);
        checkOutput("idle_valid", out_valid, 1'b0);
        checkOutput("idle_I", I_sum, 0);
        checkOutput("idle_Q", Q_sum, 0);
        checkOutput("idle_fill", fill_done, 1'b0);
        checkOutput("idle_strobes", validCount, 0);

        // Test 2: first fill
        refillCheck("t2");

        // Test 3: full-scale negative samples replace the whole window
        countMark = validCount;
        for (int j = 0; j < 16; j++) applyStimulus(-16'sd32768, -16'sd32768, 1'b0);
        idleCycles(2);
        checkOutput("t3_valid", out_valid, 1'b1);
        checkOutput("t3_I", I_sum, 0);
        checkOutput("t3_Q", Q_sum, -1048576);
        idleCycles(2);
        checkOutput("t3_strobes", validCount - countMark, 16);

        // Test 4: (1000,0) with random gaps, each strobe checked against the mixed-window model
        capI.delete();
        capQ.delete();
        lastI     = 0;
        lastQ     = -1048576;
        captureEn = 1'b1;
        holdEn    = 1'b1;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(16'sd1000, 16'sd0, 1'b0);
            idleCycles($urandom_range(0, 3));
        end
        idleCycles(4);
        captureEn = 1'b0;
        holdEn    = 1'b0;
        checkOutput("t4_strobes", capI.size(), 16);
        for (int j = 1; j <= 16; j++) begin
            if (capI.size() >= j) begin
                checkOutput($sformatf("t4_I_%0d", j), capI[j-1], 1000 * j);
                checkOutput($sformatf("t4_Q_%0d", j), capQ[j-1], 1000 * j - 65536 * (16 - j));
            end
        end
        checkOutput("t4_final_I", I_sum, 16000);
        checkOutput("t4_final_Q", Q_sum, 16000);

        // Test 5: clear with a sample, while the previous sample's result is in flight
        countMark = validCount;
        applyStimulus(16'sd2000, 16'sd0, 1'b0);
        applyStimulus(16'sd5000, 16'sd0, 1'b1);
        checkOutput("t5_fill", fill_done, 1'b0);
        idleCycles(3);
        checkOutput("t5_killed", validCount - countMark, 0);
        checkOutput("t5_keep_I", I_sum, 16000);
        checkOutput("t5_keep_Q", Q_sum, 16000);
        refillCheck("t5");

        // Test 6: asynchronous reset the cycle after an accept
        countMark = validCount;
        applyStimulus(16'sd3000, 16'sd0, 1'b0);
        reset_n = 1'b0;
        #2;
        checkOutput("t6_async_I", I_sum, 0);
        idleCycles(2);
        checkOutput("t6_rst_valid", out_valid, 1'b0);
        checkOutput("t6_rst_Q", Q_sum, 0);
        checkOutput("t6_rst_fill", fill_done, 1'b0);
        reset_n = 1'b1;
        idleCycles(3);
        checkOutput("t6_no_strobe", validCount - countMark, 0);
        refillCheck("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
